// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_WIDTH      = 16;
endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the completed word is
// presented combinationally on the edge that accepts its fourth byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [1:0]  byte_index;
    logic [23:0] shift_reg;

    assign word          = {byte_in, shift_reg};
    assign word_complete = accept && (byte_index == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_index <= 2'd0;
            shift_reg  <= 24'd0;
        end else if (clear) begin
            byte_index <= 2'd0;
            shift_reg  <= 24'd0;
        end else if (accept) begin
            byte_index <= byte_index + 2'd1;
            shift_reg  <= {byte_in, shift_reg[23:8]};
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Receives a length-prefixed, XOR-checksummed program stream, writes it to
// instruction memory word by word and releases the CPU once the load checks out.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 mem_write_en,
    output logic [31:0]          mem_write_address,
    output logic [31:0]          mem_write_data,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_error,
    output logic [LEN_WIDTH-1:0] word_count
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    loader_state_t        state;
    logic [LEN_WIDTH-1:0] length;
    logic [LEN_WIDTH-1:0] length_next;
    logic [7:0]           checksum;
    logic                 accept;
    logic                 start_taken;
    logic [31:0]          packed_word;
    logic                 word_complete;

    assign byte_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                         (state == DATA)   || (state == CHECK);
    assign accept      = byte_valid && byte_ready;
    assign start_taken = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign length_next = {byte_in, length[7:0]};

    assign cpu_hold   = (state != DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

    word_packer u_word_packer (
        .clock         (clock),
        .reset         (reset),
        .byte_in       (byte_in),
        .accept        (accept && (state == DATA)),
        .clear         (start_taken),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            length            <= '0;
            checksum          <= 8'd0;
            word_count        <= '0;
            mem_write_en      <= 1'b0;
            mem_write_address <= 32'd0;
            mem_write_data    <= 32'd0;
        end else begin
            mem_write_en <= 1'b0;
            if (start_taken) begin
                state      <= LEN_LO;
                length     <= '0;
                checksum   <= 8'd0;
                word_count <= '0;
            end else if (accept) begin
                case (state)
                    LEN_LO: begin
                        length[7:0] <= byte_in;
                        checksum    <= checksum ^ byte_in;
                        state       <= LEN_HI;
                    end
                    LEN_HI: begin
                        length[15:8] <= byte_in;
                        checksum     <= checksum ^ byte_in;
                        // Oversize programs are refused before any word is written.
                        if (length_next == '0)
                            state <= CHECK;
                        else if ({16'd0, length_next} > DEPTH)
                            state <= ERROR;
                        else
                            state <= DATA;
                    end
                    DATA: begin
                        checksum <= checksum ^ byte_in;
                        if (word_complete) begin
                            mem_write_en      <= 1'b1;
                            mem_write_data    <= packed_word;
                            mem_write_address <= {14'd0, word_count, 2'b00};
                            word_count        <= word_count + 16'd1;
                            if (word_count + 16'd1 == length)
                                state <= CHECK;
                        end
                    end
                    CHECK: begin
                        state <= (byte_in == checksum) ? DONE : ERROR;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: full-size instance plus a 4-word instance for overflow.
module tb_instruction_loader;
    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready, mem_write_en, cpu_hold, load_done, load_error;
    logic [31:0] mem_write_address, mem_write_data;
    logic [15:0] word_count;

    logic        b_byte_ready, b_mem_write_en, b_cpu_hold, b_load_done, b_load_error;
    logic [31:0] b_mem_write_address, b_mem_write_data;
    logic [15:0] b_word_count;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_b = 0;
    logic [7:0]  frame[$];

    instruction_loader #(.ADDR_WIDTH(8)) u_dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_write_en(mem_write_en),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
        .word_count(word_count)
    );

    instruction_loader #(.ADDR_WIDTH(2)) u_dut_small (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(b_byte_ready), .mem_write_en(b_mem_write_en),
        .mem_write_address(b_mem_write_address), .mem_write_data(b_mem_write_data),
        .cpu_hold(b_cpu_hold), .load_done(b_load_done), .load_error(b_load_error),
        .word_count(b_word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_write_en) begin
            wr_addr.push_back(mem_write_address);
            wr_data.push_back(mem_write_data);
        end
        if (b_mem_write_en) wr_b++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit poke);
        int gap;
        bit ok;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        start      = poke;
        ok         = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            ok = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (!ok) check_val("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int gap_max, input int poke_idx);
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], gap_max, i == poke_idx);
        tick();
    endtask

    task automatic load_two_word_frame(input logic [7:0] cksum);
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01, 8'h00, 8'h00, cksum};
    endtask

    task automatic check_two_writes(input string tag);
        check_val({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check_val({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
            check_val({tag, "_data0"}, wr_data[0], 32'h0000_0013);
            check_val({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
            check_val({tag, "_data1"}, wr_data[1], 32'h0000_0133);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check_val({tag, "_wen"},   32'(mem_write_en), 32'd0);
        check_val({tag, "_addr"},  mem_write_address, 32'd0);
        check_val({tag, "_data"},  mem_write_data, 32'd0);
        check_val({tag, "_hold"},  32'(cpu_hold), 32'd1);
        check_val({tag, "_done"},  32'(load_done), 32'd0);
        check_val({tag, "_err"},   32'(load_error), 32'd0);
        check_val({tag, "_wc"},    32'(word_count), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();

        // start with a simultaneous byte in IDLE: the byte must not be taken
        wr_addr.delete(); wr_data.delete();
        start = 1'b1; byte_valid = 1'b1; byte_in = 8'h55;
        tick();
        start = 1'b0; byte_valid = 1'b0;
        check_val("lenlo_ready", 32'(byte_ready), 32'd1);
        load_two_word_frame(8'h23);
        send_frame(0, -1);
        check_two_writes("good");
        check_val("good_done", 32'(load_done), 32'd1);
        check_val("good_err",  32'(load_error), 32'd0);
        check_val("good_hold", 32'(cpu_hold), 32'd0);
        check_val("good_wc",   32'(word_count), 32'd2);
        check_val("good_ready", 32'(byte_ready), 32'd0);
        check_val("small_good_done", 32'(b_load_done), 32'd1);

        // restart from DONE, then a bad checksum
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        check_val("restart_done", 32'(load_done), 32'd0);
        check_val("restart_hold", 32'(cpu_hold), 32'd1);
        check_val("restart_wc",   32'(word_count), 32'd0);
        load_two_word_frame(8'h00);
        send_frame(0, -1);
        check_two_writes("bad");
        check_val("bad_err",  32'(load_error), 32'd1);
        check_val("bad_done", 32'(load_done), 32'd0);
        check_val("bad_hold", 32'(cpu_hold), 32'd1);
        check_val("bad_wc",   32'(word_count), 32'd2);

        // restart from ERROR, throttled stream, start pulsed mid-DATA
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        check_val("rerr_err", 32'(load_error), 32'd0);
        load_two_word_frame(8'h23);
        send_frame(3, 4);
        check_two_writes("thr");
        check_val("thr_done", 32'(load_done), 32'd1);
        check_val("thr_wc",   32'(word_count), 32'd2);

        // zero length
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0, -1);
        check_val("zero_done", 32'(load_done), 32'd1);
        check_val("zero_wc",   32'(word_count), 32'd0);
        check_val("zero_nwr",  32'(wr_addr.size()), 32'd0);
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h01};
        send_frame(0, -1);
        check_val("zero_bad_err",  32'(load_error), 32'd1);
        check_val("zero_bad_done", 32'(load_done), 32'd0);

        // overflow on the 4-word instance
        wr_b = 0;
        pulse_start();
        frame = '{8'h05, 8'h00};
        send_frame(0, -1);
        check_val("ovf_err",   32'(b_load_error), 32'd1);
        check_val("ovf_ready", 32'(b_byte_ready), 32'd0);
        check_val("ovf_hold",  32'(b_cpu_hold), 32'd1);
        check_val("ovf_big_ready", 32'(byte_ready), 32'd1);

        // reset mid-word, then a fresh load must not see the stale bytes
        frame = '{8'h13, 8'h00};
        send_frame(0, -1);
        reset = 1'b0;
        #2;
        check_reset_outputs("midrst");
        check_val("ovf_nwr", 32'(wr_b), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(0, -1);
        check_val("post_done", 32'(load_done), 32'd1);
        check_val("post_nwr",  32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check_val("post_addr", wr_addr[0], 32'h0000_0000);
            check_val("post_data", wr_data[0], 32'hDDCC_BBAA);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
